// File: rtl/merge_sort_pkg.sv
// Shared definitions for the streaming fp32 merge sorter.
//   WIDTH    : data word width (IEEE-754 binary32)
//   DEPTH    : words per frame (power of two)
//   LOGD     : log2(DEPTH), also the number of merge passes
//   SENTINEL : largest finite fp32 value, used as a fill word
//   state_t  : top-level frame sequencing states
package merge_sort_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int LOGD  = 4;
    localparam int PTR_W = LOGD + 1;   // pointers must reach DEPTH (one past the end)

    localparam logic [WIDTH-1:0] SENTINEL = 32'h7f7f_ffff;

    typedef logic [LOGD-1:0]  idx_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        MERGE  = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/merge_sort_vsd_core_fp32_lt.sv
// Combinational fp32 "less than" on raw bit patterns (no arithmetic).
//   a, b : fp32 operands
//   lt   : 1 when a orders strictly before b
// Differing signs: the negative operand is smaller (so -0 < +0).
// Both positive: unsigned magnitude compare; both negative: reversed.
// NaNs and denormals get no special treatment.
module fp32_lt
    import merge_sort_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    // Sign-magnitude ordering of the two bit patterns
    always_comb begin
        lt = 1'b0;
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            lt = a[WIDTH-1];
        end else if (a[WIDTH-1] == 1'b0) begin
            lt = (a[WIDTH-2:0] < b[WIDTH-2:0]);
        end else begin
            lt = (a[WIDTH-2:0] > b[WIDTH-2:0]);
        end
    end

endmodule

// File: rtl/merge_sort_vsd_core.sv
// Streaming fp32 sorter: loads DEPTH words (one per clock), sorts them with a
// bottom-up merge sort (one destination write per clock), then streams them
// out ascending on op. A new frame starts only after res.
//   clk      : clock, all state on posedge
//   res      : asynchronous active-high reset (banks keep their contents)
//   data_bus : input word, sampled every cycle while loading
//   op       : registered sorted output word; holds the maximum when finished
module merge_sort_vsd_core
    import merge_sort_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] op
);

    logic [WIDTH-1:0] reg_bank [0:DEPTH-1];
    logic [WIDTH-1:0] tmp_bank [0:DEPTH-1];

    state_t state_r, state_nxt_s;
    idx_t   ld_cnt_r, rd_cnt_r, k_r;
    ptr_t   i_r, j_r, base_r, w_r;
    logic   parity_r;   // 0: reg_bank -> tmp_bank, 1: tmp_bank -> reg_bank

    ptr_t             lend_s, rend_s, k_ext_s;
    logic [WIDTH-1:0] left_s, right_s, pick_s;
    logic             r_lt_l_s, take_left_s, pair_done_s, pass_done_s, last_pass_s;

    fp32_lt u_lt (
        .a  (right_s),
        .b  (left_s),
        .lt (r_lt_l_s)
    );

    // Merge datapath: run bounds, source reads and the stable left/right choice
    always_comb begin
        lend_s  = base_r + w_r;
        rend_s  = base_r + {w_r[PTR_W-2:0], 1'b0};
        k_ext_s = {1'b0, k_r} + ptr_t'(1);
        if (parity_r) begin
            left_s  = tmp_bank[i_r[LOGD-1:0]];
            right_s = tmp_bank[j_r[LOGD-1:0]];
        end else begin
            left_s  = reg_bank[i_r[LOGD-1:0]];
            right_s = reg_bank[j_r[LOGD-1:0]];
        end
        // Ties go left so equal keys keep their input order
        if (i_r == lend_s) begin
            take_left_s = 1'b0;
        end else if (j_r == rend_s) begin
            take_left_s = 1'b1;
        end else begin
            take_left_s = ~r_lt_l_s;
        end
        if (take_left_s) begin
            pick_s = left_s;
        end else begin
            pick_s = right_s;
        end
        pair_done_s = (k_ext_s == rend_s);
        pass_done_s = (k_r == idx_t'(DEPTH - 1));
        last_pass_s = (w_r == ptr_t'(DEPTH / 2));
    end

    // Next-state logic for frame sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (ld_cnt_r == idx_t'(DEPTH - 1)) begin
                    state_nxt_s = MERGE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            MERGE: begin
                if (pass_done_s && last_pass_s) begin
                    state_nxt_s = OUTPUT;
                end else begin
                    state_nxt_s = MERGE;
                end
            end
            OUTPUT: begin
                if (rd_cnt_r == idx_t'(DEPTH - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = OUTPUT;
                end
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, merge pointers and the registered output word
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ld_cnt_r <= '0;
            rd_cnt_r <= '0;
            k_r      <= '0;
            i_r      <= '0;
            j_r      <= '0;
            base_r   <= '0;
            w_r      <= ptr_t'(1);
            parity_r <= 1'b0;
            op       <= '0;
        end else begin
            case (state_r)
                LOAD: begin
                    ld_cnt_r <= ld_cnt_r + idx_t'(1);
                    // Right run of the first pair starts one word in
                    j_r      <= w_r;
                end
                MERGE: begin
                    k_r <= k_r + idx_t'(1);
                    if (take_left_s) begin
                        i_r <= i_r + ptr_t'(1);
                    end else begin
                        j_r <= j_r + ptr_t'(1);
                    end
                    if (pair_done_s) begin
                        if (pass_done_s) begin
                            base_r   <= '0;
                            i_r      <= '0;
                            j_r      <= {w_r[PTR_W-2:0], 1'b0};
                            w_r      <= {w_r[PTR_W-2:0], 1'b0};
                            parity_r <= ~parity_r;
                        end else begin
                            base_r <= k_ext_s;
                            i_r    <= k_ext_s;
                            j_r    <= k_ext_s + w_r;
                        end
                    end
                end
                OUTPUT: begin
                    op       <= reg_bank[rd_cnt_r];
                    rd_cnt_r <= rd_cnt_r + idx_t'(1);
                end
                DONE: begin
                    op <= op;
                end
                default: begin
                    op <= op;
                end
            endcase
        end
    end

    // Primary bank: frame capture while loading, odd-pass merge destination
    always_ff @(posedge clk) begin
        if (!res) begin
            if (state_r == LOAD) begin
                reg_bank[ld_cnt_r] <= data_bus;
            end else if ((state_r == MERGE) && parity_r) begin
                reg_bank[k_r] <= pick_s;
            end
        end
    end

    // Scratch bank: even-pass merge destination
    always_ff @(posedge clk) begin
        if (!res) begin
            if ((state_r == MERGE) && !parity_r) begin
                tmp_bank[k_r] <= pick_s;
            end
        end
    end

endmodule

// File: tb/tb_merge_sort_vsd_core.sv
module tb_merge_sort_vsd_core;
    import merge_sort_pkg::*;

    typedef logic [31:0] frame_t [16];

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] data_bus = 32'h0;
    logic [31:0] op;

    int checks = 0;
    int errors = 0;

    merge_sort_vsd_core dut (
        .clk      (clk),
        .res      (res),
        .data_bus (data_bus),
        .op       (op)
    );

    always #5 clk = ~clk;

    // Maps an fp32 bit pattern to an unsigned key whose natural order is the fp32 order
    function automatic logic [31:0] order_key(input logic [31:0] v);
        if (v[31]) return ~v;
        else       return v | 32'h8000_0000;
    endfunction

    task automatic model_sort(input frame_t f, output frame_t s);
        logic [31:0] v;
        int j;
        s = f;
        for (int i = 1; i < 16; i++) begin
            v = s[i];
            j = i - 1;
            while (j >= 0 && order_key(s[j]) > order_key(v)) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = v;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input frame_t got, input frame_t exp);
        for (int k = 0; k < 16; k++) check($sformatf("%s[%0d]", name, k), got[k], exp[k]);
    endtask

    // Hold reset for a few cycles; op must be cleared
    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_op", op, 32'h0);
    endtask

    // Release reset, feed frame f, check op every cycle for ncyc cycles.
    // abort_at > 0 asserts res asynchronously after that cycle and checks op clears.
    task automatic run_frame(input string tag, input frame_t f, input int ncyc, input int abort_at);
        frame_t s;
        logic [31:0] exp;
        bit aborted;
        model_sort(f, s);
        aborted = 1'b0;
        res = 1'b0;
        data_bus = f[0];
        for (int n = 1; n <= ncyc && !aborted; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n < 81)       exp = 32'h0;
            else if (n <= 96) exp = s[n-81];
            else              exp = s[15];
            check($sformatf("%s_cyc%0d", tag, n), op, exp);
            if (n < 16) data_bus = f[n];
            else        data_bus = $urandom();
            if (n == abort_at) begin
                #2 res = 1'b1;
                #1 check($sformatf("%s_abort_op", tag), op, 32'h0);
                aborted = 1'b1;
            end
        end
        res = 1'b1;
        repeat (2) @(negedge clk);
        check($sformatf("%s_post_reset_op", tag), op, 32'h0);
    endtask

    initial begin
        frame_t f, s, e;
        logic [31:0] pool [4];

        res = 1'b0;
        #1 res = 1'b1;
        repeat (3) @(negedge clk);
        check("initial_reset_op", op, 32'h0);

        // Bench frame and its hand-sorted result
        f = '{32'hBDB851EC, 32'hBDB851EC, 32'h3F000000, 32'h40C00000, 32'hC0400000,
              32'h41300000, 32'h41100000, 32'h408B851F, 32'h408B851F, 32'h408B851F,
              32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F,
              32'h408B851F};
        e = '{32'hC0400000, 32'hBDB851EC, 32'hBDB851EC, 32'h3F000000, 32'h408B851F,
              32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F,
              32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h40C00000, 32'h41100000,
              32'h41300000};
        model_sort(f, s);
        pin("model_t2", s, e);

        // Abort mid-merge, then a full frame must sort cleanly from index 0
        run_frame("abort_merge", f, 40, 40);
        for (int k = 0; k < 16; k++) f[k] = 32'(15 - k);
        for (int k = 0; k < 16; k++) e[k] = 32'(k);
        model_sort(f, s);
        pin("model_t3", s, e);
        run_frame("descending", f, 100, 0);

        // Timing: exact latency and long hold of the maximum
        f = '{32'hBDB851EC, 32'hBDB851EC, 32'h3F000000, 32'h40C00000, 32'hC0400000,
              32'h41300000, 32'h41100000, 32'h408B851F, 32'h408B851F, 32'h408B851F,
              32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F, 32'h408B851F,
              32'h408B851F};
        run_frame("bench_frame", f, 150, 0);

        // Signs and signed zeros
        for (int k = 0; k < 16; k++) f[k] = SENTINEL;
        f[0] = 32'h80000000; f[1] = 32'h00000000; f[2] = 32'hBF800000; f[3] = 32'h3F800000;
        for (int k = 0; k < 16; k++) e[k] = 32'h7F7FFFFF;
        e[0] = 32'hBF800000; e[1] = 32'h80000000; e[2] = 32'h00000000; e[3] = 32'h3F800000;
        model_sort(f, s);
        pin("model_t4", s, e);
        run_frame("signs", f, 100, 0);

        // Abort while streaming out (op is non-zero then)
        run_frame("abort_output", f, 88, 88);

        // All equal
        for (int k = 0; k < 16; k++) f[k] = 32'h41200000;
        model_sort(f, s);
        check("model_t6_first", s[0], 32'h41200000);
        check("model_t6_last", s[15], 32'h41200000);
        run_frame("all_equal", f, 100, 0);

        // Random frames, some drawn from a small pool to force duplicates
        pool = '{32'h80000000, 32'h00000000, 32'hC1200000, 32'h3F800000};
        for (int r = 0; r < 100; r++) begin
            for (int k = 0; k < 16; k++) begin
                if (r % 3 == 0) f[k] = pool[$urandom_range(0, 3)];
                else            f[k] = $urandom();
            end
            run_frame($sformatf("rand%0d", r), f, 98, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
